convolution_3x3: RTL and testbench



---
 rtl/convolution_3x3.sv | 95 +++++++++
 tb/tb_convolution_3x3.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/convolution_3x3.sv
// convolution_3x3: streaming 3x3 Gaussian blur (weights 1-2-1 / 2-4-2 / 1-2-1, sum >> 4)
// over an 8-bit greyscale raster stream, one pixel in and one pixel out per clock.
// History is a 2R+3 sample delay line split into three 3-tap window rows joined by
// two line-buffer segments, so each row of the window sits exactly R samples apart.
module convolution_3x3 #(
  parameter int WORD_SIZE = 8,
  parameter int ROW_SIZE  = 540
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] inputPixel,
  output logic [WORD_SIZE-1:0] outputPixel
);

  // Weighted sum needs 4 extra bits: total weight is 16.
  localparam int SUM_W    = WORD_SIZE + 4;
  // Each line-buffer segment covers the ages between two window rows (R - 3 samples).
  localparam int LB_DEPTH = ROW_SIZE - 3;

  // Window rows: index 0 is the newest sample of that row.
  logic [WORD_SIZE-1:0] bot_p0_q [3];   // ages 0, 1, 2
  logic [WORD_SIZE-1:0] mid_p0_q [3];   // ages R, R+1, R+2
  logic [WORD_SIZE-1:0] top_p0_q [3];   // ages 2R, 2R+1, 2R+2
  logic [WORD_SIZE-1:0] lb1_q [LB_DEPTH]; // ages 3 .. R-1
  logic [WORD_SIZE-1:0] lb2_q [LB_DEPTH]; // ages R+3 .. 2R-1

  logic [SUM_W-1:0]     sum_d;
  logic [WORD_SIZE-1:0] pix_d;
  logic [WORD_SIZE-1:0] out_p1_q;

  // Zero-extend a pixel to the accumulator width.
  function automatic logic [SUM_W-1:0] ext(input logic [WORD_SIZE-1:0] p);
    return {{(SUM_W-WORD_SIZE){1'b0}}, p};
  endfunction

  // Divide by the total weight of 16, truncating; the result always fits WORD_SIZE bits.
  function automatic logic [WORD_SIZE-1:0] scale_down(input logic [SUM_W-1:0] s);
    return s[SUM_W-1:4];
  endfunction

  // ---- stage p0: sample history (window rows and line buffers) ----
  // Shift the whole delay line by one sample per clock; reset clears all history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        bot_p0_q[i] <= '0;
        mid_p0_q[i] <= '0;
        top_p0_q[i] <= '0;
      end
      for (int i = 0; i < LB_DEPTH; i++) begin
        lb1_q[i] <= '0;
        lb2_q[i] <= '0;
      end
    end else begin
      bot_p0_q[0] <= inputPixel;
      bot_p0_q[1] <= bot_p0_q[0];
      bot_p0_q[2] <= bot_p0_q[1];
      lb1_q[0]    <= bot_p0_q[2];
      for (int i = 1; i < LB_DEPTH; i++) begin
        lb1_q[i] <= lb1_q[i-1];
      end
      mid_p0_q[0] <= lb1_q[LB_DEPTH-1];
      mid_p0_q[1] <= mid_p0_q[0];
      mid_p0_q[2] <= mid_p0_q[1];
      lb2_q[0]    <= mid_p0_q[2];
      for (int i = 1; i < LB_DEPTH; i++) begin
        lb2_q[i] <= lb2_q[i-1];
      end
      top_p0_q[0] <= lb2_q[LB_DEPTH-1];
      top_p0_q[1] <= top_p0_q[0];
      top_p0_q[2] <= top_p0_q[1];
    end
  end

  // Weighted 3x3 sum over the current window, scaled back to pixel width.
  always_comb begin
    sum_d = ext(bot_p0_q[0])        + (ext(bot_p0_q[1]) << 1) + ext(bot_p0_q[2])
          + (ext(mid_p0_q[0]) << 1) + (ext(mid_p0_q[1]) << 2) + (ext(mid_p0_q[2]) << 1)
          + ext(top_p0_q[0])        + (ext(top_p0_q[1]) << 1) + ext(top_p0_q[2]);
    pix_d = scale_down(sum_d);
  end

  // ---- stage p1: registered output ----
  // Register the filtered pixel; cleared immediately on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_p1_q <= '0;
    end else begin
      out_p1_q <= pix_d;
    end
  end

  assign outputPixel = out_p1_q;

endmodule

// File: tb/tb_convolution_3x3.sv
// Bench for convolution_3x3 with an 8-pixel row: directed reset, constant-field,
// impulse, truncation and mid-stream-reset sequences plus a random stream, all
// checked against a queue-based sample-history model of the 3x3 blur.
module tb_convolution_3x3;

  localparam int W = 8;
  localparam int R = 8;
  localparam int HIST = 2*R + 3;

  logic         clk;
  logic         rst;
  logic [W-1:0] inputPixel;
  logic [W-1:0] outputPixel;

  int tests;
  int fails;

  // Reference history: hist[d] is the sample of age d relative to the last edge.
  int hist[$];
  int tap_d[9];
  int tap_w[9];

  convolution_3x3 #(.WORD_SIZE(W), .ROW_SIZE(R)) dut (
    .clk        (clk),
    .rst        (rst),
    .inputPixel (inputPixel),
    .outputPixel(outputPixel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    hist.delete();
    for (int i = 0; i < HIST; i++) hist.push_back(0);
  endtask

  // Filter over the history as it stands before the next sample is taken.
  function automatic int model_out();
    int s;
    s = 0;
    for (int i = 0; i < 9; i++) s += tap_w[i] * hist[tap_d[i]];
    return s >> 4;
  endfunction

  // Directed impulse weight seen j edges after the impulse edge.
  function automatic int imp_w(input int j);
    case (j)
      1, 3, 17, 19:  return 1;
      2, 9, 11, 18:  return 2;
      10:            return 4;
      default:       return 0;
    endcase
  endfunction

  // Present one pixel, clock it in, and compare the output with the model.
  task automatic step(input logic [W-1:0] pix, input string tag);
    int exp;
    exp = model_out();
    hist.push_front(int'(pix));
    void'(hist.pop_back());
    inputPixel = pix;
    @(posedge clk);
    #1;
    check(tag, outputPixel, W'(exp));
  endtask

  // Asynchronous reset between edges, held across one edge, released away from edges.
  task automatic do_reset(input string tag);
    #2;
    rst = 1'b0;
    #1;
    check({tag, "_async"}, outputPixel, 8'h00);
    @(posedge clk);
    #1;
    check({tag, "_held"}, outputPixel, 8'h00);
    rst = 1'b1;
    model_clear();
  endtask

  // Impulse of amplitude amp, observed for n_after edges after it (inclusive of edge k).
  task automatic impulse(input logic [W-1:0] amp, input int n_after, input string tag);
    for (int i = 0; i < 4; i++) step(8'h00, {tag, "_pre"});
    for (int j = 0; j <= n_after; j++) begin
      step((j == 0) ? amp : 8'h00, {tag, "_model"});
      check({tag, "_directed"}, outputPixel, W'((int'(amp) * imp_w(j)) >> 4));
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    tap_d = '{0, 1, 2, R, R+1, R+2, 2*R, 2*R+1, 2*R+2};
    tap_w = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
    model_clear();

    // Reset held with full-scale input: output stays zero.
    rst = 1'b0;
    inputPixel = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("reset_hold", outputPixel, 8'h00);
    end
    rst = 1'b1;

    // Constant field 0x64: ramps through partial sums, settles from edge 20.
    for (int e = 1; e <= 26; e++) begin
      step(8'h64, "const_model");
      if (e >= 2*R + 4) check("const_steady", outputPixel, 8'h64);
    end

    // Asynchronous reset while output is non-zero.
    do_reset("midrun_reset");

    // Full-scale constant: no wrap of the 4080 internal sum.
    for (int e = 1; e <= 24; e++) step(8'hFF, "max_model");
    check("max_steady", outputPixel, 8'hFF);

    do_reset("pre_impulse");

    // Impulse response with the spec's 0xA0 amplitude.
    impulse(8'hA0, 22, "impulse");

    // Truncation: centre-tap contribution 12 -> 0, 20 -> 1.
    impulse(8'h03, 11, "trunc3");
    check("trunc3_centre", outputPixel, 8'h00);
    for (int i = 0; i < 10; i++) step(8'h00, "trunc_flush");
    impulse(8'h05, 10, "trunc5");
    check("trunc5_centre", outputPixel, 8'h01);
    for (int i = 0; i < 12; i++) step(8'h00, "trunc_flush2");

    // Mid-stream reset after edge k+10, then an identical impulse with no residue.
    do_reset("pre_repeat");
    impulse(8'hA0, 10, "impulse_cut");
    check("impulse_cut_peak", outputPixel, 8'h28);
    do_reset("impulse_cut_reset");
    for (int i = 0; i < 2*R + 4; i++) begin
      step(8'h00, "residue_model");
      check("residue_zero", outputPixel, 8'h00);
    end
    impulse(8'hA0, 22, "impulse_again");

    // Random stream against the model, including border-crossing windows.
    do_reset("pre_random");
    for (int i = 0; i < 300; i++) step(W'($urandom_range(0, 255)), "random");

    // Random stream interrupted by a reset partway through.
    do_reset("random_reset");
    for (int i = 0; i < 60; i++) step(W'($urandom_range(0, 255)), "random_after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
